gmii_tx_arbiter: RTL and testbench

- Two-requester arbiter/sequencer for the single GMII transmit path that feeds the RGMII TX converter (gmii_tx_clk domain).
- Requesters: ch0 (ARP/ICMP reply path) and ch1 (UDP video stream from the dual-OV5640 pipeline).
- Grants the path one whole frame at a time, round-robin. Registers the muxed byte stream, enforces the inter-frame gap, and guards against stalled or runaway requesters.

---
 rtl/gmii_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_gmii_tx_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_arbiter.sv
// Round-robin, frame-at-a-time arbiter for the shared GMII transmit path.
// Registers the muxed byte stream, enforces the inter-frame gap and guards against stalled/runaway requesters.
module gmii_tx_arbiter #(
  parameter int IFG_CYCLES    = 12,
  parameter int START_TIMEOUT = 64,
  parameter int MAX_FRAME     = 1530
) (
  input  logic       gmii_tx_clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       en0,
  input  logic [7:0] txd0,
  output logic       gnt0,
  input  logic       req1,
  input  logic       en1,
  input  logic [7:0] txd1,
  output logic       gnt1,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       trunc_err
);

  typedef enum logic [1:0] {IDLE, GRANT, XMIT, IFG} state_t;

  localparam logic [10:0] TIMEOUT_LAST = 11'(START_TIMEOUT - 1);
  localparam logic [10:0] MAX_CNT      = 11'(MAX_FRAME);
  localparam logic [7:0]  IFG_LAST     = 8'(IFG_CYCLES - 1);

  state_t      state;
  logic        last_served;
  logic [10:0] cnt;
  logic [7:0]  ifg_cnt;

  logic        req_sel;
  logic        en_sel;
  logic [7:0]  txd_sel;
  logic        pick;
  logic [10:0] cnt_inc;

  // last_served doubles as the current owner while in GRANT/XMIT.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    req_sel = 1'b0;
    en_sel  = 1'b0;
    txd_sel = 8'h00;
    if (last_served) begin
      req_sel = req1;
      en_sel  = en1;
      txd_sel = txd1;
    end else begin
      req_sel = req0;
      en_sel  = en0;
      txd_sel = txd0;
    end
    pick    = (req0 && req1) ? ~last_served : req1;
    cnt_inc = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= 1'b1;
      cnt         <= '0;
      ifg_cnt     <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      gmii_tx_en  <= 1'b0;
      gmii_txd    <= 8'h00;
      busy        <= 1'b0;
      trunc_err   <= 1'b0;
    end else begin
      trunc_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt0        <= ~pick;
            gnt1        <= pick;
            last_served <= pick;
            cnt         <= '0;
            busy        <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (en_sel) begin
            gmii_tx_en <= 1'b1;
            gmii_txd   <= txd_sel;
            cnt        <= 11'd1;
            state      <= XMIT;
          end else if (!req_sel || cnt == TIMEOUT_LAST) begin
            // Withdrawn or stalled requester: release without owing an IFG.
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        XMIT: begin
          if (en_sel && cnt < MAX_CNT) begin
            gmii_tx_en <= 1'b1;
            gmii_txd   <= txd_sel;
            cnt        <= cnt_inc;
          end else begin
            // Normal frame end, or forced truncation when en is still high.
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            trunc_err  <= en_sel;
            cnt        <= '0;
            ifg_cnt    <= '0;
            state      <= IFG;
          end
        end
        IFG: begin
          if (ifg_cnt == IFG_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed testbench for gmii_tx_arbiter: grants, round-robin, IFG, timeout, truncation and reset.
`timescale 1ns/1ps
module tb_gmii_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, en0, req1, en1;
  logic [7:0] txd0, txd1;
  logic       gnt0, gnt1, gmii_tx_en, busy, trunc_err;
  logic [7:0] gmii_txd;

  int vectors = 0;
  int miscompares = 0;

  always #4 clk = ~clk;

  gmii_tx_arbiter #(.IFG_CYCLES(12), .START_TIMEOUT(64), .MAX_FRAME(1530)) dut (
    .gmii_tx_clk(clk), .rst_n(rst_n),
    .req0(req0), .en0(en0), .txd0(txd0), .gnt0(gnt0),
    .req1(req1), .en1(en1), .txd1(txd1), .gnt1(gnt1),
    .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
    .busy(busy), .trunc_err(trunc_err)
  );

  // Advance one active edge; outputs are sampled and inputs driven 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; en0 = 1'b0; txd0 = 8'h00;
    req1 = 1'b0; en1 = 1'b0; txd1 = 8'h00;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b1; en0 = 1'b1; txd0 = 8'hAA;
    req1 = 1'b1; en1 = 1'b1; txd1 = 8'h55;
    repeat (3) step();
    vectors++; if (gnt0 !== 1'b0) begin miscompares++; $display("FAIL reset_gnt0: got %b expected 0", gnt0); end
    vectors++; if (gnt1 !== 1'b0) begin miscompares++; $display("FAIL reset_gnt1: got %b expected 0", gnt1); end
    vectors++; if (gmii_tx_en !== 1'b0) begin miscompares++; $display("FAIL reset_tx_en: got %b expected 0", gmii_tx_en); end
    vectors++; if (gmii_txd !== 8'h00) begin miscompares++; $display("FAIL reset_txd: got %h expected 00", gmii_txd); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (trunc_err !== 1'b0) begin miscompares++; $display("FAIL reset_trunc: got %b expected 0", trunc_err); end
    do_reset();
  endtask

  task automatic test_single_ch1();
    do_reset();
    req1 = 1'b1;
    step();
    vectors++; if ({gnt0, gnt1, busy, gmii_tx_en} !== 4'b0110) begin miscompares++; $display("FAIL single_grant: got gnt0/gnt1/busy/en=%b expected 0110", {gnt0, gnt1, busy, gmii_tx_en}); end
    for (int i = 0; i < 100; i++) begin
      en1 = 1'b1; txd1 = 8'(i);
      step();
      vectors++; if ({gmii_tx_en, gmii_txd} !== {1'b1, 8'(i)}) begin miscompares++; $display("FAIL single_byte%0d: got en=%b txd=%h expected en=1 txd=%h", i, gmii_tx_en, gmii_txd, 8'(i)); end
    end
    en1 = 1'b0; req1 = 1'b0; txd1 = 8'h00;
    step();
    vectors++; if ({gmii_tx_en, gnt1, busy} !== 3'b001) begin miscompares++; $display("FAIL single_end: got en/gnt1/busy=%b expected 001", {gmii_tx_en, gnt1, busy}); end
    repeat (11) step();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_ifg_busy: got %b expected 1", busy); end
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_ifg_done: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    step();
    vectors++; if ({gnt0, gnt1} !== 2'b10) begin miscompares++; $display("FAIL tie1_grant: got gnt0/gnt1=%b expected 10", {gnt0, gnt1}); end
    for (int i = 0; i < 64; i++) begin
      en0 = 1'b1; txd0 = 8'(8'hA0 + i);
      en1 = 1'b1; txd1 = 8'hFF;
      step();
      vectors++; if ({gmii_tx_en, gmii_txd} !== {1'b1, 8'(8'hA0 + i)}) begin miscompares++; $display("FAIL ch0_byte%0d: got en=%b txd=%h expected en=1 txd=%h", i, gmii_tx_en, gmii_txd, 8'(8'hA0 + i)); end
    end
    en0 = 1'b0; en1 = 1'b0;
    step();
    vectors++; if ({gmii_tx_en, gmii_txd, gnt0} !== 10'd0) begin miscompares++; $display("FAIL ch0_end: got en=%b txd=%h gnt0=%b expected all 0", gmii_tx_en, gmii_txd, gnt0); end
    for (int k = 1; k <= 12; k++) begin
      step();
      vectors++; if ({gmii_tx_en, gnt0, gnt1} !== 3'b000) begin miscompares++; $display("FAIL ifg_quiet%0d: got en/gnt0/gnt1=%b expected 000", k, {gmii_tx_en, gnt0, gnt1}); end
    end
    step();
    vectors++; if ({gnt0, gnt1} !== 2'b01) begin miscompares++; $display("FAIL tie2_grant: got gnt0/gnt1=%b expected 01", {gnt0, gnt1}); end
    for (int i = 0; i < 4; i++) begin
      en1 = 1'b1; txd1 = 8'(8'h10 + i);
      step();
      vectors++; if ({gmii_tx_en, gmii_txd} !== {1'b1, 8'(8'h10 + i)}) begin miscompares++; $display("FAIL ch1_byte%0d: got en=%b txd=%h expected en=1 txd=%h", i, gmii_tx_en, gmii_txd, 8'(8'h10 + i)); end
    end
    en1 = 1'b0;
    repeat (13) step();
    vectors++; if ({gnt0, gnt1} !== 2'b00) begin miscompares++; $display("FAIL tie3_early: got gnt0/gnt1=%b expected 00", {gnt0, gnt1}); end
    step();
    vectors++; if ({gnt0, gnt1} !== 2'b10) begin miscompares++; $display("FAIL tie3_grant: got gnt0/gnt1=%b expected 10", {gnt0, gnt1}); end
    req0 = 1'b0; req1 = 1'b0;
    step();
    vectors++; if ({gnt0, busy} !== 2'b00) begin miscompares++; $display("FAIL withdraw: got gnt0/busy=%b expected 00", {gnt0, busy}); end
  endtask

  task automatic test_timeout();
    do_reset();
    req0 = 1'b1;
    step();
    vectors++; if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL to_grant: got %b expected 1", gnt0); end
    req1 = 1'b1;
    for (int k = 1; k < 64; k++) begin
      step();
      vectors++; if ({gnt0, gnt1, gmii_tx_en} !== 3'b100) begin miscompares++; $display("FAIL to_hold%0d: got gnt0/gnt1/en=%b expected 100", k, {gnt0, gnt1, gmii_tx_en}); end
    end
    step();
    vectors++; if ({gnt0, gnt1, gmii_tx_en} !== 3'b000) begin miscompares++; $display("FAIL to_revoke: got gnt0/gnt1/en=%b expected 000", {gnt0, gnt1, gmii_tx_en}); end
    step();
    vectors++; if ({gnt0, gnt1, gmii_tx_en} !== 3'b010) begin miscompares++; $display("FAIL to_next: got gnt0/gnt1/en=%b expected 010", {gnt0, gnt1, gmii_tx_en}); end
    req0 = 1'b0; req1 = 1'b0;
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL to_cleanup: got busy=%b expected 0", busy); end
  endtask

  task automatic test_truncate();
    int hi_cnt = 0;
    int tr_cnt = 0;
    do_reset();
    req1 = 1'b1;
    step();
    for (int j = 0; j < 2000; j++) begin
      en1 = 1'b1; txd1 = 8'(j);
      step();
      hi_cnt += int'(gmii_tx_en);
      tr_cnt += int'(trunc_err);
      if (j == 1529) begin
        vectors++; if ({gmii_tx_en, gmii_txd} !== {1'b1, 8'(j)}) begin miscompares++; $display("FAIL trunc_last_byte: got en=%b txd=%h expected en=1 txd=%h", gmii_tx_en, gmii_txd, 8'(j)); end
      end
      if (j == 1530) begin
        vectors++; if ({gmii_tx_en, gmii_txd, gnt1, trunc_err} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin miscompares++; $display("FAIL trunc_cut: got en=%b txd=%h gnt1=%b trunc=%b expected 0 00 0 1", gmii_tx_en, gmii_txd, gnt1, trunc_err); end
        req1 = 1'b0;
      end
    end
    vectors++; if (hi_cnt !== 1530) begin miscompares++; $display("FAIL trunc_len: got %0d expected 1530", hi_cnt); end
    vectors++; if (tr_cnt !== 1) begin miscompares++; $display("FAIL trunc_pulses: got %0d expected 1", tr_cnt); end
    vectors++; if ({gnt1, busy, gmii_tx_en} !== 3'b000) begin miscompares++; $display("FAIL trunc_after: got gnt1/busy/en=%b expected 000", {gnt1, busy, gmii_tx_en}); end
    en1 = 1'b0;
  endtask

  task automatic test_ignore_and_reset();
    do_reset();
    req1 = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      en1 = 1'b1; txd1 = 8'(8'h30 + i);
      en0 = i[0]; txd0 = 8'hEE;
      step();
      vectors++; if ({gmii_tx_en, gmii_txd} !== {1'b1, 8'(8'h30 + i)}) begin miscompares++; $display("FAIL ignore_byte%0d: got en=%b txd=%h expected en=1 txd=%h", i, gmii_tx_en, gmii_txd, 8'(8'h30 + i)); end
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if ({gmii_tx_en, gnt1, busy} !== 3'b000) begin miscompares++; $display("FAIL async_reset: got en/gnt1/busy=%b expected 000", {gmii_tx_en, gnt1, busy}); end
    step();
    req1 = 1'b0; en1 = 1'b0; en0 = 1'b0; req0 = 1'b1;
    rst_n = 1'b1;
    step();
    vectors++; if ({gnt0, gnt1} !== 2'b10) begin miscompares++; $display("FAIL post_reset_grant: got gnt0/gnt1=%b expected 10", {gnt0, gnt1}); end
    req0 = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_ch1();
    test_back_to_back();
    test_timeout();
    test_truncate();
    test_ignore_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
